// File: rtl/systolic_skew_feeder_if.sv
// Operand handshake and skewed-output bundle between an upstream source and the systolic west-edge feeder.
interface systolic_skew_feeder_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*WIDTH-1:0]   in_data;
  logic                     in_last;
  logic                     tile_clear;
  logic [LANES*WIDTH-1:0]   out_data;
  logic [LANES-1:0]         done_flag;
  logic                     tile_done;
  logic                     busy;

  modport master (
    output in_valid, in_data, in_last, tile_clear,
    input  in_ready, out_data, done_flag, tile_done, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, tile_clear,
    output in_ready, out_data, done_flag, tile_done, busy
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// West-edge systolic feeder: vector FIFO, diagonal lane skew, per-lane done flags.
// Optional macro FEEDER_BUBBLE_CNT_EN adds a saturating bubble_cnt output.
module systolic_skew_feeder #(
    parameter int WIDTH = 16,
    parameter int LANES = 4,
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    systolic_skew_feeder_if.slave bus
`ifdef FEEDER_BUBBLE_CNT_EN
    ,
    output logic [15:0] bubble_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int VW = LANES * WIDTH;
    localparam int DW = $clog2(LANES) + 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t                       state, state_next;
    logic   [VW:0]                mem [DEPTH];
    logic   [AW-1:0]              wr_ptr, rd_ptr;
    logic   [CW-1:0]              count;
    logic                         fifo_full, fifo_empty;
    logic                         locked;
    logic                         push, pop;
    logic   [VW:0]                head;
    logic   [VW-1:0]              vec_in;
    logic                         last_in;
    logic   [DW-1:0]              drain_cnt;
    logic   [VW-1:0]              data_p0;
    logic   [LANES-1:0]           last_p;
    logic   [LANES-1:0]           done_q;
    logic                         tile_done_q;
    logic                         busy_q;
    logic   [LANES-1:0][WIDTH-1:0] out_lanes;

    assign fifo_full    = (count == CW'(DEPTH));
    assign fifo_empty   = (count == '0);
    assign bus.in_ready = !fifo_full && !locked;
    assign push         = bus.in_valid && bus.in_ready;
    assign head         = mem[rd_ptr];

    // FIFO storage is not reset; emptiness comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.in_last, bus.in_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        vec_in     = '0;
        last_in    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_next = STREAM;
            end
            STREAM: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    vec_in  = head[VW-1:0];
                    last_in = head[VW];
                    if (head[VW]) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0 && done_q[LANES-1]) state_next = DONE;
            end
            DONE: begin
                if (bus.tile_clear) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            locked    <= 1'b0;
            drain_cnt <= '0;
            busy_q    <= 1'b0;
        end else begin
            busy_q <= (state_next != IDLE);
            if (state == DONE && bus.tile_clear) locked <= 1'b0;
            else if (push && bus.in_last)        locked <= 1'b1;
            if (state == STREAM && state_next == DRAIN)
                drain_cnt <= DW'(LANES - 1);
            else if (state == DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // Stage 0: popped entry or zero vector, plus the tile-end marker
    always_ff @(posedge clk) begin
        if (reset) begin
            data_p0 <= '0;
            last_p  <= '0;
        end else begin
            data_p0 <= vec_in;
            last_p  <= (last_p << 1) | LANES'(last_in);
        end
    end

    // Stages 1..LANES-1: lane i rides i extra registers
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if (i == 0) begin : g_direct
            assign out_lanes[i] = data_p0[0 +: WIDTH];
        end else begin : g_skew
            logic [WIDTH-1:0] lane_p [i];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < i; k++) lane_p[k] <= '0;
                end else begin
                    lane_p[0] <= data_p0[i*WIDTH +: WIDTH];
                    for (int k = 1; k < i; k++) lane_p[k] <= lane_p[k-1];
                end
            end
            assign out_lanes[i] = lane_p[i-1];
        end
    end

    // Done flags trail the marker by one cycle, so each rises after its lane's last element
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q      <= '0;
            tile_done_q <= 1'b0;
        end else begin
            tile_done_q <= last_p[LANES-1];
            if (state == DONE && bus.tile_clear) done_q <= '0;
            else                                 done_q <= done_q | last_p;
        end
    end

    assign bus.out_data  = out_lanes;
    assign bus.done_flag = done_q;
    assign bus.tile_done = tile_done_q;
    assign bus.busy      = busy_q;

`ifdef FEEDER_BUBBLE_CNT_EN
    logic bubble;
    assign bubble = (state == STREAM) && fifo_empty;

    always_ff @(posedge clk) begin
        if (reset)                                bubble_cnt <= '0;
        else if (state == DONE && bus.tile_clear) bubble_cnt <= '0;
        else if (bubble && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: queue-based tile model checked every cycle, plus literal timing pins.
module tb_systolic_skew_feeder;
  localparam int WIDTH = 16;
  localparam int LANES = 4;
  localparam int DEPTH = 8;
  localparam int VW    = LANES * WIDTH;
  localparam int TR    = 2048;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();
`ifdef FEEDER_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  systolic_skew_feeder #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FEEDER_BUBBLE_CNT_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic last; logic [VW-1:0] data; } ent_t;
  ent_t        q[$];
  int          mst = 0;          // 0 idle, 1 stream, 2 drain, 3 done
  bit          locked = 0;
  bit          tl_v = 0;
  int          tl = 0;           // edge index at which the last vector was popped
  int          bub = 0;
  int          ecnt = 0;
  logic [VW-1:0] hist [LANES];   // hist[k] = vector that entered the skew k edges ago

  initial begin
    ent_t e;
    int nxt;
    bit rdy, psh;
    logic [VW-1:0] nvec;
    forever begin
      @(posedge clk);
      ecnt++;
      if (reset) begin
        q.delete();
        mst = 0; locked = 0; tl_v = 0; bub = 0;
        for (int i = 0; i < LANES; i++) hist[i] = '0;
      end else begin
        rdy  = (q.size() < DEPTH) && !locked;
        psh  = bus.in_valid && rdy;
        nvec = '0;
        nxt  = mst;
        case (mst)
          0: if (q.size() > 0) nxt = 1;
          1: begin
            if (q.size() > 0) begin
              e = q.pop_front();
              nvec = e.data;
              if (e.last) begin tl = ecnt; tl_v = 1; nxt = 2; end
            end else if (bub < 65535) bub++;
          end
          2: if (ecnt >= tl + LANES + 1) nxt = 3;
          default: if (bus.tile_clear) begin nxt = 0; locked = 0; tl_v = 0; bub = 0; end
        endcase
        if (psh) begin
          q.push_back({bus.in_last, bus.in_data});
          if (bus.in_last) locked = 1;
        end
        for (int i = LANES - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = nvec;
        mst = nxt;
      end
    end
  end

  function automatic logic [VW-1:0] exp_out();
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = hist[i][i*WIDTH +: WIDTH];
    return r;
  endfunction

  function automatic logic [LANES-1:0] exp_df();
    logic [LANES-1:0] r;
    for (int i = 0; i < LANES; i++) r[i] = tl_v && (ecnt >= tl + 1 + i);
    return r;
  endfunction

  // ---------------- per-cycle compare + trace ----------------
  logic [VW-1:0]    tr_out [TR];
  logic [LANES-1:0] tr_df  [TR];
  logic             tr_td  [TR];

  initial begin
    forever begin
      @(negedge clk);
      if (ecnt > 0) begin
        chk("out_data",  64'(bus.out_data),  64'(exp_out()));
        chk("done_flag", 64'(bus.done_flag), 64'(exp_df()));
        chk("tile_done", 64'(bus.tile_done), 64'(tl_v && (ecnt == tl + LANES)));
        chk("busy",      64'(bus.busy),      64'(mst != 0));
        chk("in_ready",  64'(bus.in_ready),  64'((q.size() < DEPTH) && !locked));
`ifdef FEEDER_BUBBLE_CNT_EN
        chk("bubble_cnt", 64'(bubble_cnt), 64'(bub));
`endif
        if (ecnt < TR) begin
          tr_out[ecnt] = bus.out_data;
          tr_df[ecnt]  = bus.done_flag;
          tr_td[ecnt]  = bus.tile_done;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [VW-1:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [VW-1:0] d, input logic l);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed %0b, expected 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus.done_flag !== '1 && n < 60) begin tick(); n++; end
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL wait_done_timeout: done_flag=%b, expected %b", bus.done_flag, {LANES{1'b1}});
    end
    tick();
  endtask

  task automatic clear_tile();
    bus.tile_clear = 1'b1;
    tick();
    bus.tile_clear = 1'b0;
    chk("clear_done_flag", 64'(bus.done_flag), 64'(0));
    chk("clear_busy",      64'(bus.busy),      64'(0));
  endtask

  function automatic logic [WIDTH-1:0] lane(input logic [VW-1:0] v, input int i);
    return v[i*WIDTH +: WIDTH];
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.tile_clear = 1'b0;

    // reset held for three edges
    repeat (3) tick();
    chk("rst_out_data",  64'(bus.out_data),  64'(0));
    chk("rst_done_flag", 64'(bus.done_flag), 64'(0));
    chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
    chk("rst_busy",      64'(bus.busy),      64'(0));
    reset = 1'b0;

    // three back-to-back vectors, first pop at edge n+3
    n = ecnt;
    send(pk(1, 2, 3, 4), 1'b0);
    send(pk(5, 6, 7, 8), 1'b0);
    send(pk(9, 10, 11, 12), 1'b1);
    wait_done();
    chk("t2_lane0_a", 64'(lane(tr_out[n+3], 0)), 64'(1));
    chk("t2_lane0_b", 64'(lane(tr_out[n+4], 0)), 64'(5));
    chk("t2_lane0_c", 64'(lane(tr_out[n+5], 0)), 64'(9));
    chk("t2_lane3_a", 64'(lane(tr_out[n+6], 3)), 64'(4));
    chk("t2_lane3_b", 64'(lane(tr_out[n+7], 3)), 64'(8));
    chk("t2_lane3_c", 64'(lane(tr_out[n+8], 3)), 64'(12));
    chk("t2_df0_pre",  64'(tr_df[n+5][0]), 64'(0));
    chk("t2_df0_rise", 64'(tr_df[n+6][0]), 64'(1));
    chk("t2_df3_pre",  64'(tr_df[n+8][3]), 64'(0));
    chk("t2_df3_rise", 64'(tr_df[n+9][3]), 64'(1));
    chk("t2_td_pre",   64'(tr_td[n+8]), 64'(0));
    chk("t2_td_pulse", 64'(tr_td[n+9]), 64'(1));
    chk("t2_td_post",  64'(tr_td[n+10]), 64'(0));
    chk("t2_done_ready", 64'(bus.in_ready), 64'(0));
    clear_tile();

    // upstream gap mid-tile: two bubbles before the last vector
    n = ecnt;
    send(pk(21, 22, 23, 24), 1'b0);
    send(pk(25, 26, 27, 28), 1'b0);
    send(pk(29, 30, 31, 32), 1'b0);
    repeat (3) tick();
    send(pk(33, 34, 35, 36), 1'b1);
    wait_done();
    chk("t3_lane0_v3",  64'(lane(tr_out[n+5], 0)), 64'(29));
    chk("t3_lane0_b1",  64'(lane(tr_out[n+6], 0)), 64'(0));
    chk("t3_lane0_b2",  64'(lane(tr_out[n+7], 0)), 64'(0));
    chk("t3_lane0_v4",  64'(lane(tr_out[n+8], 0)), 64'(33));
    chk("t3_lane1_v3",  64'(lane(tr_out[n+6], 1)), 64'(30));
    chk("t3_lane1_b1",  64'(lane(tr_out[n+7], 1)), 64'(0));
    chk("t3_lane3_v4",  64'(lane(tr_out[n+11], 3)), 64'(36));
`ifdef FEEDER_BUBBLE_CNT_EN
    chk("t3_bubble_cnt", 64'(bubble_cnt), 64'(2));
`endif
    clear_tile();
`ifdef FEEDER_BUBBLE_CNT_EN
    chk("t3_bubble_clr", 64'(bubble_cnt), 64'(0));
`endif

    // in_valid held for DEPTH+1 non-last vectors, then the last one
    n = ecnt;
    for (int k = 0; k <= DEPTH; k++) send(pk(100 + 4*k, 101 + 4*k, 102 + 4*k, 103 + 4*k), 1'b0);
    send(pk(200, 201, 202, 203), 1'b1);
    wait_done();
    chk("t4_lane0_first", 64'(lane(tr_out[n+3], 0)), 64'(100));
    chk("t4_lane0_ninth", 64'(lane(tr_out[n+11], 0)), 64'(132));
    chk("t4_lane0_last",  64'(lane(tr_out[n+12], 0)), 64'(200));
    clear_tile();

    // locked after last; tile_clear outside DONE ignored; next tile after clear
    send(pk(51, 52, 53, 54), 1'b0);
    send(pk(55, 56, 57, 58), 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = pk(41, 42, 43, 44);
    bus.in_last  = 1'b0;
    chk("t5_locked_ready", 64'(bus.in_ready), 64'(0));
    bus.tile_clear = 1'b1;
    tick();
    bus.tile_clear = 1'b0;
    chk("t5_clear_ignored_busy",  64'(bus.busy),     64'(1));
    chk("t5_clear_ignored_ready", 64'(bus.in_ready), 64'(0));
    wait_done();
    chk("t5_done_ready", 64'(bus.in_ready), 64'(0));
    chk("t5_done_flags", 64'(bus.done_flag), 64'(4'hF));
    clear_tile();
    chk("t5_ready_after_clear", 64'(bus.in_ready), 64'(1));
    n = ecnt;
    send(pk(41, 42, 43, 44), 1'b0);
    send(pk(45, 46, 47, 48), 1'b1);
    wait_done();
    chk("t5_next_lane0", 64'(lane(tr_out[n+3], 0)), 64'(41));
    chk("t5_next_lane2", 64'(lane(tr_out[n+6], 2)), 64'(47));
    clear_tile();

    // reset two cycles after the first pop of a five-vector tile
    for (int k = 0; k < 4; k++) send(pk(61 + k, 71 + k, 81 + k, 91 + k), 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_out",   64'(bus.out_data),  64'(0));
    chk("t6_rst_df",    64'(bus.done_flag), 64'(0));
    chk("t6_rst_busy",  64'(bus.busy),      64'(0));
    chk("t6_rst_ready", 64'(bus.in_ready),  64'(1));
    repeat (2) tick();
    chk("t6_idle_busy", 64'(bus.busy), 64'(0));
    n = ecnt;
    send(pk(7, 8, 9, 10), 1'b0);
    send(pk(11, 12, 13, 14), 1'b1);
    wait_done();
    chk("t6_fresh_lane0", 64'(lane(tr_out[n+3], 0)), 64'(7));
    chk("t6_fresh_lane3", 64'(lane(tr_out[n+7], 3)), 64'(14));
    clear_tile();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "timeout");
  end

endmodule
